// File: rtl/ring_freq_meter_if.sv
// ring_freq_meter_if: control, oscillator input and result handshake of the ring-oscillator frequency meter.
interface ring_freq_meter_if #(parameter int CNT_W = 16);
  logic enable;
  logic osc_in;
  logic start;
  logic busy;
  logic [CNT_W-1:0] count_out;
  logic overflow;
  logic valid;
  logic ready;
  modport master (output enable, osc_in, start, ready, input busy, count_out, overflow, valid);
  modport slave (input enable, osc_in, start, ready, output busy, count_out, overflow, valid);
endinterface

// File: rtl/ring_freq_meter.sv
// ring_freq_meter: gated rising-edge counter for an asynchronous ring-oscillator output.
// Define FREQ_METER_SATURATE_EN to saturate the edge counter instead of wrapping.
module ring_freq_meter #(
  parameter int GATE_CYCLES = 1000,
  parameter int CNT_W = 16,
  parameter int SYNC_STAGES = 2
) (
  input logic clk,
  input logic reset,
  ring_freq_meter_if.slave bus
);
  localparam int TW = $clog2(GATE_CYCLES);
  typedef enum logic [1:0] {IDLE, ARM, GATE, HOLD} state_t;
  state_t state, state_n;
  logic [SYNC_STAGES-1:0] sync;
  logic sync_prev, pulse, gate_end;
  logic [TW-1:0] timer;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic ovf, ovf_n;
  assign pulse = sync[SYNC_STAGES-1] & ~sync_prev;
  assign gate_end = timer == TW'(GATE_CYCLES - 1);
`ifdef FREQ_METER_SATURATE_EN
  assign cnt_n = (pulse && !(&cnt)) ? cnt + 1'b1 : cnt;
`else
  assign cnt_n = pulse ? cnt + 1'b1 : cnt;
`endif
  assign ovf_n = ovf | (pulse & (&cnt));
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = !bus.enable ? IDLE :
              state == IDLE ? (bus.start ? ARM : IDLE) :
              state == ARM ? GATE :
              state == GATE ? (gate_end ? HOLD : GATE) :
              bus.ready ? IDLE : HOLD;
  end
  always_comb begin
    bus.busy = state == ARM || state == GATE;
    bus.valid = state == HOLD;
  end
  // sync_prev tracks sync_last every cycle, so the first gate cycle only sees genuine edges
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      sync <= '0;
      sync_prev <= 1'b0;
      timer <= '0;
      cnt <= '0;
      ovf <= 1'b0;
      bus.count_out <= '0;
      bus.overflow <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], bus.osc_in};
      sync_prev <= sync[SYNC_STAGES-1];
      if (state == ARM) begin
        cnt <= '0;
        ovf <= 1'b0;
        timer <= '0;
      end else if (state == GATE) begin
        cnt <= cnt_n;
        ovf <= ovf_n;
        timer <= timer + 1'b1;
      end
      if (state == GATE && state_n == HOLD) begin
        bus.count_out <= cnt_n;
        bus.overflow <= ovf_n;
      end
    end
endmodule

// File: tb/tb_ring_freq_meter.sv
// tb_ring_freq_meter: directed table plus corner sequences for ring_freq_meter at 16-bit and 4-bit counter widths.
module tb_ring_freq_meter;
  logic clk = 0, reset = 1, enable = 0, start = 0, ready = 0, osc = 0;
  int half = 0, ph = 0, errors = 0, checks = 0;
`ifdef FREQ_METER_SATURATE_EN
  localparam int C25 = 15;
`else
  localparam int C25 = 9;
`endif
  typedef struct {int half; int c16; int o16; int c4; int o4;} vec_t;
  ring_freq_meter_if #(.CNT_W(16)) b16();
  ring_freq_meter_if #(.CNT_W(4)) b4();
  assign b16.enable = enable;
  assign b16.start = start;
  assign b16.ready = ready;
  assign b16.osc_in = osc;
  assign b4.enable = enable;
  assign b4.start = start;
  assign b4.ready = ready;
  assign b4.osc_in = osc;
  ring_freq_meter #(.GATE_CYCLES(100), .CNT_W(16), .SYNC_STAGES(2)) dut16 (.clk(clk), .reset(reset), .bus(b16));
  ring_freq_meter #(.GATE_CYCLES(100), .CNT_W(4), .SYNC_STAGES(2)) dut4 (.clk(clk), .reset(reset), .bus(b4));
  always #5 clk = ~clk;
  // oscillator of period 2*half clk cycles, held low when half is 0
  initial forever begin
    @(posedge clk);
    #2;
    if (half == 0) begin
      osc = 0;
      ph = 0;
    end else begin
      ph = ph + 1;
      if (ph >= half) begin
        ph = 0;
        osc = ~osc;
      end
    end
  end
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic set_osc(input int h);
    half = h;
    ph = 0;
    osc = 0;
    repeat (3) @(negedge clk);
  endtask
  task automatic measure(input int rep, output int lat);
    @(negedge clk);
    start = 1;
    @(negedge clk);
    start = 0;
    lat = 1;
    while (!b16.valid && lat < 300) begin
      @(negedge clk);
      lat++;
      start = rep > 0 && lat == rep;
    end
    start = 0;
  endtask
  task automatic accept(input string name);
    @(negedge clk);
    ready = 1;
    @(negedge clk);
    ready = 0;
    chk({name, "_valid_drop"}, int'(b16.valid), 0);
    chk({name, "_busy_after"}, int'(b16.busy), 0);
  endtask
  initial begin
    vec_t v[6];
    int lat, c0, ok;
    v = '{'{5, 10, 0, 10, 0}, '{2, 25, 0, C25, 1}, '{0, 0, 0, 0, 0},
          '{10, 5, 0, 5, 0}, '{25, 2, 0, 2, 0}, '{50, 1, 0, 1, 0}};
    repeat (3) @(negedge clk);
    chk("rst_valid", int'(b16.valid), 0);
    chk("rst_busy", int'(b16.busy), 0);
    chk("rst_count", int'(b16.count_out), 0);
    chk("rst_ovf", int'(b16.overflow), 0);
    reset = 0;
    enable = 1;
    for (int i = 0; i < 6; i++) begin
      set_osc(v[i].half);
      measure(0, lat);
      chk($sformatf("v%0d_latency", i), lat, 102);
      chk($sformatf("v%0d_valid4", i), int'(b4.valid), 1);
      chk($sformatf("v%0d_count16", i), int'(b16.count_out), v[i].c16);
      chk($sformatf("v%0d_ovf16", i), int'(b16.overflow), v[i].o16);
      chk($sformatf("v%0d_count4", i), int'(b4.count_out), v[i].c4);
      chk($sformatf("v%0d_ovf4", i), int'(b4.overflow), v[i].o4);
      accept($sformatf("v%0d", i));
    end
    set_osc(5);
    measure(0, lat);
    c0 = int'(b16.count_out);
    ok = 1;
    repeat (50) begin
      @(negedge clk);
      if (!b16.valid || int'(b16.count_out) != c0) ok = 0;
    end
    chk("hold_stable", ok, 1);
    chk("hold_count", c0, 10);
    accept("hold");
    chk("hold_count_kept", int'(b16.count_out), 10);
    @(negedge clk);
    start = 1;
    @(negedge clk);
    start = 0;
    repeat (41) @(negedge clk);
    chk("abort_busy_before", int'(b16.busy), 1);
    enable = 0;
    @(negedge clk);
    chk("abort_busy", int'(b16.busy), 0);
    chk("abort_valid", int'(b16.valid), 0);
    enable = 1;
    ok = 0;
    repeat (150) begin
      @(negedge clk);
      if (b16.valid) ok = 1;
    end
    chk("abort_no_valid", ok, 0);
    measure(30, lat);
    chk("repulse_latency", lat, 102);
    chk("repulse_count", int'(b16.count_out), 10);
    accept("repulse");
    enable = 0;
    @(negedge clk);
    start = 1;
    @(negedge clk);
    start = 0;
    chk("disabled_start", int'(b16.busy), 0);
    enable = 1;
    @(negedge clk);
    chk("disabled_start_later", int'(b16.busy), 0);
    @(negedge clk);
    start = 1;
    @(negedge clk);
    start = 0;
    repeat (50) @(negedge clk);
    #2 reset = 1;
    #1;
    chk("arst_valid", int'(b16.valid), 0);
    chk("arst_busy", int'(b16.busy), 0);
    chk("arst_count16", int'(b16.count_out), 0);
    chk("arst_count4", int'(b4.count_out), 0);
    @(negedge clk);
    reset = 0;
    set_osc(5);
    measure(0, lat);
    chk("fresh_latency", lat, 102);
    chk("fresh_count", int'(b16.count_out), 10);
    chk("fresh_ovf", int'(b16.overflow), 0);
    accept("fresh");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
